// File: rtl/pcd_pause_n_seq_pkg.sv
// Shared types and default timing for the Modified Miller PCD transmit sequencer.
// Default tick values: 128-tick bit period, 32-tick pause, X offset 64, Z offset 0, 256 guard ticks.
package pcd_pause_n_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_X = 2'd0,
        SEQ_Y = 2'd1,
        SEQ_Z = 2'd2
    } seq_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SOC   = 3'd1,
        DATA  = 3'd2,
        EOC0  = 3'd3,
        EOC_Y = 3'd4,
        GUARD = 3'd5
    } state_t;

    localparam int unsigned DEF_BIT_TICKS   = 128;
    localparam int unsigned DEF_PAUSE_TICKS = 32;
    localparam int unsigned DEF_X_OFFSET    = 64;
    localparam int unsigned DEF_Z_OFFSET    = 0;
    localparam int unsigned DEF_GUARD_TICKS = 256;

    // A logic 0 following a 1 is sent as Y; any other logic 0 is sent as Z.
    function automatic seq_t logic0_seq(input logic prev_one);
        return prev_one ? SEQ_Y : SEQ_Z;
    endfunction

endpackage

// File: rtl/pcd_pause_n_sequencer_window.sv
// Per-period tick counter, period-end strobe and combinational pause-window decode.
// Window is valid in the same cycle as the tick value; no backpressure.
module pause_window_gen
    import pcd_pause_n_seq_pkg::*;
#(
    parameter int TICK_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  seq_t              seq_i,
    input  logic [TICK_W-1:0] bit_ticks_i,
    input  logic [TICK_W-1:0] pause_ticks_i,
    input  logic [TICK_W-1:0] x_offset_i,
    input  logic [TICK_W-1:0] z_offset_i,
    output logic              period_end_o,
    output logic              window_o
);

    localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [TICK_W:0]   off;
    logic [TICK_W:0]   win_end;

    assign period_end_o = run_i && (tick_q == (bit_ticks_i - ONE));

    always_comb begin
        tick_d = tick_q;
        if (!run_i || period_end_o) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    // Compare at TICK_W+1 bits so offset+length cannot wrap.
    always_comb begin
        off      = (seq_i == SEQ_X) ? {1'b0, x_offset_i} : {1'b0, z_offset_i};
        win_end  = off + {1'b0, pause_ticks_i};
        window_o = run_i && (seq_i != SEQ_Y) &&
                   ({1'b0, tick_q} >= off) && ({1'b0, tick_q} < win_end);
    end

endmodule

// File: rtl/pcd_pause_n_sequencer.sv
// Turns a valid/ready bit stream into the Modified Miller pcd_pause_n waveform (SOC, X/Y/Z, EOC, guard).
// pcd_pause_n lags the tick decode by 1 cycle; a bit is taken only on the last tick of SOC/DATA periods.
module pcd_pause_n_sequencer
    import pcd_pause_n_seq_pkg::*;
#(
    parameter int TICK_W  = 10,
    parameter int GUARD_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TICK_W-1:0]  cfg_bit_ticks,
    input  logic [TICK_W-1:0]  cfg_pause_ticks,
    input  logic [TICK_W-1:0]  cfg_x_offset,
    input  logic [TICK_W-1:0]  cfg_z_offset,
    input  logic [GUARD_W-1:0] cfg_guard_ticks,
    input  logic               in_valid,
    input  logic               in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               pcd_pause_n,
    output logic               busy,
    output seq_t               seq_out,
    output logic               err_underrun,
    output logic               cfg_err
);

    localparam logic [GUARD_W:0] G_ONE = (GUARD_W+1)'(1);

    state_t             state_q, state_d;
    seq_t               seq_q, seq_d;
    logic               cur_one_q, cur_one_d;
    logic               last_q, last_d;
    logic [GUARD_W-1:0] gcnt_q, gcnt_d;
    logic               underrun_q, underrun_d;
    logic               cfg_err_q, cfg_err_d;
    logic               pause_n_q;

    logic [TICK_W-1:0]  bit_q, pause_q, xoff_q, zoff_q;
    logic [GUARD_W-1:0] guard_q;

    logic [TICK_W:0]    x_sum, z_sum;
    logic               cfg_ok;
    logic               start;
    logic               run;
    logic               period_end;
    logic               window;
    logic               xfer;
    logic               guard_done;

    always_comb begin
        x_sum  = {1'b0, cfg_x_offset} + {1'b0, cfg_pause_ticks};
        z_sum  = {1'b0, cfg_z_offset} + {1'b0, cfg_pause_ticks};
        cfg_ok = (cfg_pause_ticks != '0) &&
                 (x_sum <= {1'b0, cfg_bit_ticks}) &&
                 (z_sum <= {1'b0, cfg_bit_ticks}) &&
                 (cfg_bit_ticks >= TICK_W'(2));
    end

    assign start = (state_q == IDLE) && in_valid && cfg_ok;
    assign run   = (state_q == SOC) || (state_q == DATA) ||
                   (state_q == EOC0) || (state_q == EOC_Y);

    pause_window_gen #(
        .TICK_W (TICK_W)
    ) u_window (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (run),
        .seq_i         (seq_q),
        .bit_ticks_i   (bit_q),
        .pause_ticks_i (pause_q),
        .x_offset_i    (xoff_q),
        .z_offset_i    (zoff_q),
        .period_end_o  (period_end),
        .window_o      (window)
    );

    // Once the last bit is loaded no further transfer is offered in the frame.
    assign in_ready   = period_end && ((state_q == SOC) || ((state_q == DATA) && !last_q));
    assign xfer       = in_valid && in_ready;
    assign guard_done = ({1'b0, gcnt_q} + G_ONE) >= {1'b0, guard_q};

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        cur_one_d  = cur_one_q;
        last_d     = last_q;
        gcnt_d     = gcnt_q;
        underrun_d = 1'b0;
        cfg_err_d  = (state_q == IDLE) && in_valid && !cfg_ok;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SOC;
                    seq_d     = SEQ_Z;
                    cur_one_d = 1'b0;
                    last_d    = 1'b0;
                end
            end
            SOC, DATA: begin
                if (period_end) begin
                    if (xfer) begin
                        state_d   = DATA;
                        seq_d     = in_data ? SEQ_X : logic0_seq(cur_one_q);
                        cur_one_d = in_data;
                        last_d    = in_last;
                    end else begin
                        state_d    = EOC0;
                        seq_d      = logic0_seq(cur_one_q);
                        underrun_d = !last_q;
                    end
                end
            end
            EOC0: begin
                if (period_end) begin
                    state_d = EOC_Y;
                    seq_d   = SEQ_Y;
                end
            end
            EOC_Y: begin
                if (period_end) begin
                    state_d = GUARD;
                    seq_d   = SEQ_Y;
                    gcnt_d  = '0;
                end
            end
            GUARD: begin
                seq_d = SEQ_Y;
                if (guard_done) begin
                    state_d = IDLE;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                seq_d   = SEQ_Y;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seq_q      <= SEQ_Y;
            cur_one_q  <= 1'b0;
            last_q     <= 1'b0;
            gcnt_q     <= '0;
            underrun_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            pause_n_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            cur_one_q  <= cur_one_d;
            last_q     <= last_d;
            gcnt_q     <= gcnt_d;
            underrun_q <= underrun_d;
            cfg_err_q  <= cfg_err_d;
            pause_n_q  <= !window;
        end
    end

    // Timing is frozen for the whole frame at the cycle the frame is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_q   <= '0;
            pause_q <= '0;
            xoff_q  <= '0;
            zoff_q  <= '0;
            guard_q <= '0;
        end else if (start) begin
            bit_q   <= cfg_bit_ticks;
            pause_q <= cfg_pause_ticks;
            xoff_q  <= cfg_x_offset;
            zoff_q  <= cfg_z_offset;
            guard_q <= cfg_guard_ticks;
        end
    end

    assign pcd_pause_n  = pause_n_q;
    assign busy         = (state_q != IDLE);
    assign seq_out      = seq_q;
    assign err_underrun = underrun_q;
    assign cfg_err      = cfg_err_q;

endmodule
